// File: rtl/grant_owner_tracker_if.sv
// Bus bundle between the grant source, the clients and the ownership tracker.
// Handshake: a beat transfers on a rising clk edge where tgt_valid_o and
// tgt_ready_i are both high; once raised, tgt_valid_o stays high until the
// final (tgt_last_o) beat has transferred, and the target may hold
// tgt_ready_i low for any number of cycles.
interface grant_owner_tracker_if #(
  parameter int N     = 32,
  parameter int LEN_W = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       gnt_i;
  logic [N*LEN_W-1:0] beat_len_i;
  logic               tgt_ready_i;
  logic               tgt_valid_o;
  logic               tgt_last_o;
  logic [IDW-1:0]     owner_id_o;
  logic               busy_o;
  logic [N-1:0]       ack_o;
  logic [N-1:0]       done_o;
  logic               onehot_err_o;
  // Debug view of the FSM state (0 = IDLE, 1 = BUSY).
  logic               dbg_state_o;

  // Tracker side.
  modport slave (
    input  gnt_i, beat_len_i, tgt_ready_i,
    output tgt_valid_o, tgt_last_o, owner_id_o, busy_o,
           ack_o, done_o, onehot_err_o, dbg_state_o
  );

  // Arbiter / client / target side.
  modport master (
    output gnt_i, beat_len_i, tgt_ready_i,
    input  tgt_valid_o, tgt_last_o, owner_id_o, busy_o,
           ack_o, done_o, onehot_err_o, dbg_state_o
  );
endinterface

// File: rtl/grant_owner_tracker.sv
// Grant owner tracker: decodes a one-hot arbiter grant into an owner index,
// locks the shared target for a (len+1)-beat transfer and pulses per-client
// ack/done. A multi-hot grant seen while idle sets a sticky error flag.
// Every output comes from registers, so gnt_i has no path to any output.
module grant_owner_tracker #(
  parameter int N     = 32,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  grant_owner_tracker_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   owner_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [N-1:0]     ack_q;
  logic [N-1:0]     done_q;
  logic             err_q;

  logic [N-1:0]     one_d;
  logic             gnt_any_d;
  logic             gnt_multi_d;
  logic [IDW-1:0]   cap_id_d;
  logic [LEN_W-1:0] cap_len_d;
  logic [N-1:0]     owner_onehot_d;
  logic             last_d;
  logic             beat_fire_d;

  // Grant decode: any/multi-hot detection, owner index and its length slice.
  always_comb begin
    one_d       = '0;
    one_d[0]    = 1'b1;
    gnt_any_d   = |bus.gnt_i;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    gnt_multi_d = |(bus.gnt_i & (bus.gnt_i - one_d));
    cap_id_d    = '0;
    cap_len_d   = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.gnt_i[k]) begin
        cap_id_d  = IDW'(k);
        cap_len_d = bus.beat_len_i[k*LEN_W +: LEN_W];
      end
    end
  end

  // Owner index back to one-hot for the done pulse; beat and last-beat qualifiers.
  always_comb begin
    owner_onehot_d = '0;
    for (int k = 0; k < N; k++) begin
      owner_onehot_d[k] = (owner_q == IDW'(k));
    end
    last_d      = (state_q == BUSY) && (cnt_q == len_q);
    beat_fire_d = (state_q == BUSY) && bus.tgt_ready_i;
  end

  // Ownership FSM with registered pulses, beat counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_multi_d) begin
            err_q <= 1'b1;
          end else if (gnt_any_d) begin
            owner_q <= cap_id_d;
            len_q   <= cap_len_d;
            cnt_q   <= '0;
            ack_q   <= bus.gnt_i;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (beat_fire_d) begin
            if (last_d) begin
              // Counter is left alone on the last beat so len = all-ones never wraps.
              state_q <= IDLE;
              done_q  <= owner_onehot_d;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tgt_valid_o  = (state_q == BUSY);
  assign bus.busy_o       = (state_q == BUSY);
  assign bus.tgt_last_o   = last_d;
  assign bus.owner_id_o   = owner_q;
  assign bus.ack_o        = ack_q;
  assign bus.done_o       = done_q;
  assign bus.onehot_err_o = err_q;
  assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_grant_owner_tracker.sv
// Bench for grant_owner_tracker: an N=32 and an N=1 instance driven one
// cycle at a time; expected output words are queued as each cycle is driven
// and compared one time unit after the following rising edge.
module tb_grant_owner_tracker;
  localparam int W = 74;

  logic clk;
  logic rst32;
  logic rst1;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] gnt;
    logic [3:0]  len;
    logic        rdy;
    logic        v;
    logic        l;
    logic        b;
    logic        e;
    int          own;
    logic        a;
    logic        d;
  } vec_t;

  vec_t tbl[$];

  grant_owner_tracker_if #(.N(32), .LEN_W(4)) bus32();
  grant_owner_tracker_if #(.N(1),  .LEN_W(4)) bus1();

  grant_owner_tracker #(.N(32), .LEN_W(4)) dut32 (
    .clk   (clk),
    .reset (rst32),
    .bus   (bus32)
  );

  grant_owner_tracker #(.N(1), .LEN_W(4)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: {valid, last, busy, err, state, owner[4:0], ack[31:0], done[31:0]}
  function automatic logic [W-1:0] pk(input logic v, input logic l, input logic b,
                                      input logic e, input logic st, input logic [4:0] own,
                                      input logic [31:0] ack, input logic [31:0] done);
    return {v, l, b, e, st, own, ack, done};
  endfunction

  function automatic string show(input logic [W-1:0] x);
    return $sformatf("v=%b l=%b busy=%b err=%b st=%b own=%0d ack=%h done=%h",
                     x[73], x[72], x[71], x[70], x[69], x[68:64], x[63:32], x[31:0]);
  endfunction

  function automatic logic [W-1:0] act32();
    return pk(bus32.tgt_valid_o, bus32.tgt_last_o, bus32.busy_o, bus32.onehot_err_o,
              bus32.dbg_state_o, bus32.owner_id_o, bus32.ack_o, bus32.done_o);
  endfunction

  function automatic logic [W-1:0] act1();
    return pk(bus1.tgt_valid_o, bus1.tgt_last_o, bus1.busy_o, bus1.onehot_err_o,
              bus1.dbg_state_o, 5'(bus1.owner_id_o), 32'(bus1.ack_o), 32'(bus1.done_o));
  endfunction

  // Queue one expected output word; ack/done land on the expected owner's bit.
  task automatic expect_out(input logic v, input logic l, input logic b, input logic e,
                            input int own, input logic a, input logic d);
    logic [4:0]  o;
    logic [31:0] av;
    logic [31:0] dv;
    o  = own[4:0];
    av = a ? (32'h1 << o) : 32'h0;
    dv = d ? (32'h1 << o) : 32'h0;
    exp_q.push_back(pk(v, l, b, e, b, o, av, dv));
  endtask

  task automatic check_now(input logic [W-1:0] act, input string nm);
    logic [W-1:0] ex;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %s, but no expected value was queued", nm, show(act));
    end else begin
      ex = exp_q.pop_front();
      if (act !== ex) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, show(act), show(ex));
      end
    end
  endtask

  task automatic step32(input logic [31:0] g, input logic [3:0] len, input logic rdy,
                        input string nm);
    bus32.gnt_i       = g;
    bus32.beat_len_i  = {32{len}};
    bus32.tgt_ready_i = rdy;
    @(posedge clk);
    #1;
    check_now(act32(), nm);
  endtask

  task automatic step1(input logic g, input logic [3:0] len, input logic rdy,
                       input string nm);
    bus1.gnt_i       = g;
    bus1.beat_len_i  = len;
    bus1.tgt_ready_i = rdy;
    @(posedge clk);
    #1;
    check_now(act1(), nm);
  endtask

  task automatic add(input logic [31:0] g, input logic [3:0] len, input logic rdy,
                     input logic v, input logic l, input logic b, input logic e,
                     input int own, input logic a, input logic d);
    vec_t x;
    x.gnt = g; x.len = len; x.rdy = rdy;
    x.v = v; x.l = l; x.b = b; x.e = e; x.own = own; x.a = a; x.d = d;
    tbl.push_back(x);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Vectors: inputs held for one cycle, expected outputs after that edge.
    //   gnt           len  rdy  v  l  b  e  own a  d
    // Client 8, len 3, ready held high; beat_len changes mid-transfer are ignored.
    add(32'h0000_0100, 4'd3, 1, 1, 0, 1, 0, 8, 1, 0);
    add(32'h0000_0000, 4'd9, 1, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0000, 4'd0, 1, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0000, 4'd0, 1, 1, 1, 1, 0, 8, 0, 0);
    add(32'h0000_0000, 4'd0, 1, 0, 0, 0, 0, 8, 0, 1);
    add(32'h0000_0000, 4'd0, 0, 0, 0, 0, 0, 8, 0, 0);
    // Same transfer, ready 1,0,0,1,1,0,1 while a multi-hot grant sits on gnt_i.
    add(32'h0000_0100, 4'd3, 0, 1, 0, 1, 0, 8, 1, 0);
    add(32'h0000_0003, 4'd0, 1, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 0, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 0, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 1, 1, 0, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 1, 1, 1, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 0, 1, 1, 1, 0, 8, 0, 0);
    add(32'h0000_0003, 4'd0, 1, 0, 0, 0, 0, 8, 0, 1);
    add(32'h0000_0000, 4'd0, 0, 0, 0, 0, 0, 8, 0, 0);
    // Multi-hot grant in IDLE: sticky error, no capture; then a client 0 transfer.
    add(32'h0000_0005, 4'd0, 1, 0, 0, 0, 1, 8, 0, 0);
    add(32'h0000_0000, 4'd0, 1, 0, 0, 0, 1, 8, 0, 0);
    add(32'h0000_0001, 4'd1, 1, 1, 0, 1, 1, 0, 1, 0);
    add(32'h0000_0000, 4'd1, 1, 1, 1, 1, 1, 0, 0, 0);
    add(32'h0000_0000, 4'd1, 1, 0, 0, 0, 1, 0, 0, 1);
    add(32'h0000_0000, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0);

    bus32.gnt_i = '0; bus32.beat_len_i = '0; bus32.tgt_ready_i = 1'b0;
    bus1.gnt_i  = '0; bus1.beat_len_i  = '0; bus1.tgt_ready_i  = 1'b0;
    rst32 = 1'b1;
    rst1  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0;
    rst1  = 1'b0;

    // Reset state, then 10 idle cycles.
    expect_out(0, 0, 0, 0, 0, 0, 0);
    check_now(act32(), "reset32");
    for (int i = 0; i < 10; i++) begin
      expect_out(0, 0, 0, 0, 0, 0, 0);
      step32(32'h0, 4'd0, i[0], $sformatf("idle32[%0d]", i));
    end

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      expect_out(tbl[i].v, tbl[i].l, tbl[i].b, tbl[i].e, tbl[i].own, tbl[i].a, tbl[i].d);
      step32(tbl[i].gnt, tbl[i].len, tbl[i].rdy, $sformatf("tbl[%0d]", i));
    end

    // 16-beat transfer for client 31 (err still set), then back-to-back grant.
    expect_out(1, 0, 1, 1, 31, 1, 0);
    step32(32'h8000_0000, 4'd15, 1, "len15_grant");
    for (int b = 1; b <= 15; b++) begin
      expect_out(1, (b == 15), 1, 1, 31, 0, 0);
      step32(32'h0, 4'd15, 1, $sformatf("len15_beat[%0d]", b));
    end
    expect_out(0, 0, 0, 1, 31, 0, 1);
    step32(32'h0, 4'd15, 1, "len15_done");
    expect_out(1, 1, 1, 1, 0, 1, 0);
    step32(32'h0000_0001, 4'd0, 1, "b2b_ack0");
    expect_out(0, 0, 0, 1, 0, 0, 1);
    step32(32'h0, 4'd0, 1, "b2b_done0");

    // Reset during the 2nd beat of a 4-beat transfer: immediate clear, no done.
    expect_out(1, 0, 1, 1, 8, 1, 0);
    step32(32'h0000_0100, 4'd3, 1, "rst_mid_grant");
    expect_out(1, 0, 1, 1, 8, 0, 0);
    step32(32'h0, 4'd3, 1, "rst_mid_beat1");
    #2;
    rst32 = 1'b1;
    #1;
    expect_out(0, 0, 0, 0, 0, 0, 0);
    check_now(act32(), "rst_async");
    @(posedge clk);
    #1;
    expect_out(0, 0, 0, 0, 0, 0, 0);
    check_now(act32(), "rst_held");
    rst32 = 1'b0;
    expect_out(0, 0, 0, 0, 0, 0, 0);
    step32(32'h0, 4'd3, 1, "rst_after_idle");
    expect_out(1, 1, 1, 0, 2, 1, 0);
    step32(32'h0000_0004, 4'd0, 1, "rst_after_ack2");
    expect_out(0, 0, 0, 0, 2, 0, 1);
    step32(32'h0, 4'd0, 1, "rst_after_done2");
    expect_out(0, 0, 0, 0, 2, 0, 0);
    step32(32'h0, 4'd0, 0, "rst_after_idle2");

    // N=1 instance: reset state, backpressured 4-beat, len 0 and len 15 back-to-back.
    expect_out(0, 0, 0, 0, 0, 0, 0);
    check_now(act1(), "n1_reset");
    for (int i = 0; i < 3; i++) begin
      expect_out(0, 0, 0, 0, 0, 0, 0);
      step1(1'b0, 4'd3, 1'b1, $sformatf("n1_idle[%0d]", i));
    end
    expect_out(1, 0, 1, 0, 0, 1, 0);
    step1(1'b1, 4'd3, 1'b0, "n1_grant");
    expect_out(1, 0, 1, 0, 0, 0, 0);
    step1(1'b1, 4'd0, 1'b0, "n1_stall");
    expect_out(1, 0, 1, 0, 0, 0, 0);
    step1(1'b0, 4'd0, 1'b1, "n1_beat1");
    expect_out(1, 0, 1, 0, 0, 0, 0);
    step1(1'b0, 4'd0, 1'b1, "n1_beat2");
    expect_out(1, 1, 1, 0, 0, 0, 0);
    step1(1'b0, 4'd0, 1'b1, "n1_beat3");
    expect_out(1, 1, 1, 0, 0, 0, 0);
    step1(1'b0, 4'd0, 1'b0, "n1_stall_last");
    expect_out(0, 0, 0, 0, 0, 0, 1);
    step1(1'b0, 4'd0, 1'b1, "n1_done");
    expect_out(1, 1, 1, 0, 0, 1, 0);
    step1(1'b1, 4'd0, 1'b1, "n1_len0_ack");
    expect_out(0, 0, 0, 0, 0, 0, 1);
    step1(1'b1, 4'd0, 1'b1, "n1_len0_done");
    expect_out(1, 0, 1, 0, 0, 1, 0);
    step1(1'b1, 4'd15, 1'b1, "n1_len15_ack");
    for (int b = 1; b <= 15; b++) begin
      expect_out(1, (b == 15), 1, 0, 0, 0, 0);
      step1(1'b0, 4'd15, 1'b1, $sformatf("n1_len15_beat[%0d]", b));
    end
    expect_out(0, 0, 0, 0, 0, 0, 1);
    step1(1'b0, 4'd15, 1'b1, "n1_len15_done");
    expect_out(0, 0, 0, 0, 0, 0, 0);
    step1(1'b0, 4'd0, 1'b0, "n1_final_idle");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grant_owner_tracker.md
Name: grant_owner_tracker

Overview:
- Sits on the resource side of the single-cycle fixed-priority arbiter and consumes its one-hot grant vector.
- Decodes the grant to a binary owner index and locks ownership for a multi-beat transfer to a shared target over a valid/ready handshake.
- Reports per-client accept and completion pulses back to the clients, and drives busy_o so the arbiter's requests can be masked while the target is owned.
- Flags any non-one-hot grant as a protocol error.

Parameters:
- N, 32, number of clients (grant width); N=1 must be supported.
- LEN_W, 4, width of each client's beat-length field; a transfer is (len+1) beats, 1..2^LEN_W.
- IDW, (N>1 ? $clog2(N) : 1), owner index width; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- gnt_i  input  N  grant vector from arbiter, expected one-hot or zero.
- beat_len_i  input  N*LEN_W  per-client length; client k uses bits [k*LEN_W +: LEN_W].
- tgt_ready_i  input  1  target accepts a beat.
- tgt_valid_o  output  1  beat offered to target.
- tgt_last_o  output  1  current beat is the final beat.
- owner_id_o  output  IDW  binary index of the current owner.
- busy_o  output  1  ownership locked; arbiter requests are masked with this.
- ack_o  output  N  one-cycle one-hot pulse: owner's grant accepted.
- done_o  output  N  one-cycle one-hot pulse: owner's transfer complete.
- onehot_err_o  output  1  sticky: a multi-hot grant was seen in IDLE.

Behaviour:
- Reset:
  - Asynchronous; state goes to IDLE.
  - All outputs go to 0, including owner_id_o, the beat counter and onehot_err_o.
  - A transfer in flight is abandoned with no done_o pulse.
- States: IDLE and BUSY.
- IDLE, gnt_i == 0:
  - Stay in IDLE.
  - tgt_valid_o = 0, busy_o = 0.
- IDLE, gnt_i one-hot with bit k set, at the clock edge:
  - Capture owner_id_o = k and len = beat_len_i slice k.
  - Clear the beat counter.
  - Enter BUSY.
  - ack_o[k] = 1 for exactly the first BUSY cycle.
  - Latency from grant to first tgt_valid_o is 1 cycle.
- IDLE, gnt_i with more than one bit set:
  - No capture; stay in IDLE.
  - onehot_err_o goes to 1 on the next edge and stays high until reset.
  - No ack_o pulse.
- BUSY:
  - busy_o = 1 and tgt_valid_o = 1 continuously.
  - tgt_valid_o never drops before the last handshake.
  - gnt_i is ignored, including multi-hot values (no error flagged).
  - owner_id_o and the captured len hold stable; changes on beat_len_i have no effect.
- Beat counting:
  - The counter (LEN_W bits) increments on each tgt_valid_o && tgt_ready_i.
  - tgt_last_o = BUSY && (cnt == len).
  - len = 2^LEN_W-1 must not overflow: the last beat occurs at cnt = all-ones, with no wrap before it.
- Last-beat handshake (tgt_valid_o && tgt_ready_i && tgt_last_o):
  - Next edge: state goes to IDLE, busy_o = 0, tgt_valid_o = 0.
  - done_o[owner] = 1 for exactly that one cycle.
  - owner_id_o retains its value until the next capture.
- Back-to-back transfers:
  - In the cycle done_o is high (IDLE), a valid one-hot gnt_i is captured normally.
  - Minimum gap between transfers is therefore 1 idle cycle.
- Simultaneous pulses:
  - ack_o and done_o are never high in the same cycle.
  - Each is zero or one-hot.
- len = 0:
  - A single beat; tgt_last_o is high on the first BUSY cycle.
  - With tgt_ready_i high: ack at cycle t+1, done at t+2.
- Backpressure: tgt_ready_i low stalls indefinitely; counter and state hold.
- All outputs are registered or derived only from state and registers; there is no combinational path from gnt_i to any output.

Test Plan:
- Reset, then hold gnt_i=0 for 10 cycles -> all outputs 0, busy_o=0, tgt_valid_o=0 throughout.
- N=32, gnt_i=32'h0000_0100, beat_len slice 8 = 3, tgt_ready_i=1 -> owner_id_o=8, ack_o[8] pulse at t+1, tgt_valid_o for 4 cycles with tgt_last_o on the 4th, done_o[8] pulse at t+5, busy_o low at t+5.
- Same transfer with tgt_ready_i toggling 1,0,0,1,1,0,1 -> exactly 4 handshakes, tgt_last_o only on the 4th, done_o[8] one cycle after it; gnt_i=0x3 driven during BUSY -> onehot_err_o stays 0.
- In IDLE drive gnt_i=32'h0000_0005 -> no ack_o, state stays IDLE, onehot_err_o=1 and held; then a one-hot grant on client 0 -> normal transfer, error still 1 until reset.
- len=15 (LEN_W=4) for client 31, ready=1 -> 16 beats, owner_id_o=31, no counter wrap; a new grant to client 0 in the done_o cycle -> ack_o[0] the next cycle.
- Assert reset in the 2nd beat of a 4-beat transfer -> outputs 0 immediately (asynchronous), no done_o pulse; after release, a new grant works. Repeat basic directed tests with N=1.
